regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 81 ++++++++
 tb/tb_regfile_sb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with a per-register pending scoreboard.
// Reads are combinational with optional same-cycle write forwarding.
// A link write updates both wr_addr and LINK_IDX.
// busy_cnt tracks the number of pending registers.
module regfile_sb #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 3,
  parameter int unsigned LINK_IDX = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic [1:0]        we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  output logic [AW:0]       busy_cnt
);

  localparam int unsigned   DEPTH  = 1 << AW;
  localparam logic [AW-1:0] LINK_A = AW'(LINK_IDX);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] wr_hit;
  logic [DEPTH-1:0] set_vec;
  logic             wr_a_en;
  logic             wr_l_en;
  logic             set_en;
  logic             inc;
  logic             clr_a;
  logic             clr_l;

  // Decode this cycle's writes, scoreboard set and counter deltas.
  // The link write is suppressed when it aliases wr_addr, so the pair never double-counts.
  always_comb begin
    wr_hit  = '0;
    set_vec = '0;
    wr_a_en = (we != 2'b00) && (wr_addr != '0);
    wr_l_en = (we == 2'b11) && (LINK_A != '0) && (LINK_A != wr_addr);
    set_en  = sb_set && (sb_addr != '0);
    if (wr_a_en) wr_hit[wr_addr] = 1'b1;
    if (wr_l_en) wr_hit[LINK_A]  = 1'b1;
    if (set_en)  set_vec[sb_addr] = 1'b1;
    // A new producer on the same register keeps it pending, so no clear is counted.
    inc   = set_en && !pend[sb_addr];
    clr_a = wr_a_en && pend[wr_addr] && !(set_en && (sb_addr == wr_addr));
    clr_l = wr_l_en && pend[LINK_A]  && !(set_en && (sb_addr == LINK_A));
  end

  // Storage, pending bits and busy counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) mem[i] <= wr_data;
      end
      pend     <= (pend & ~wr_hit) | set_vec;
      busy_cnt <= busy_cnt + (AW+1)'(inc) - (AW+1)'(clr_a) - (AW+1)'(clr_l);
    end
  end

  // Independent combinational read ports with optional forwarding.
  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0] a;
    logic          fwd;
    assign a   = rd_addr[k*AW +: AW];
    assign fwd = (BYPASS != 0) && wr_hit[a];
    assign rd_data[k*DW +: DW] = fwd ? wr_data : ((a == '0) ? '0 : mem[a]);
    assign rd_busy[k]          = pend[a] && !fwd;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then random traffic
// against an array-based reference model.
module tb_regfile_sb;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRD   = 3;
  localparam int unsigned LINK  = 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic              clk;
  logic              rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [1:0]        we;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic [AW:0]       busy_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] m_reg  [DEPTH];
  bit            m_pend [DEPTH];

  regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .LINK_IDX(LINK), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // True when register a is written by the current we/wr_addr inputs.
  function automatic bit written(input int unsigned a);
    if (a == 0) return 1'b0;
    if (we != 2'b00 && a == int'(wr_addr)) return 1'b1;
    if (we == 2'b11 && a == LINK) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [AW-1:0] port_addr(input int k);
    return rd_addr[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] port_data(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  // Compare every read port and busy_cnt against the model, mid-cycle.
  task automatic check_now();
    int unsigned a;
    int          pop;
    logic [DW-1:0] ed;
    bit            eb;
    #1;
    for (int k = 0; k < int'(NRD); k++) begin
      a  = port_addr(k);
      ed = (a == 0) ? '0 : (written(a) ? wr_data : m_reg[a]);
      eb = (a != 0) && m_pend[a] && !written(a);
      chk($sformatf("rd_data[%0d] a=%0d", k, a), 64'(port_data(k)), 64'(ed));
      chk($sformatf("rd_busy[%0d] a=%0d", k, a), 64'(rd_busy[k]), 64'(eb));
    end
    pop = 0;
    for (int i = 0; i < int'(DEPTH); i++) pop += int'(m_pend[i]);
    chk("busy_cnt", 64'(busy_cnt), 64'(pop));
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (written(i)) begin
          m_reg[i]  = wr_data;
          m_pend[i] = 1'b0;
        end
      end
      if (sb_set && sb_addr != '0) m_pend[sb_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic idle();
    we = 2'b00; sb_set = 1'b0; wr_addr = '0; wr_data = '0; sb_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    set_rd(0, 0, 0);
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;

    // All addresses read zero and idle after reset.
    for (int a = 0; a < int'(DEPTH); a++) begin
      set_rd(a, (a + 1) % DEPTH, (a + 2) % DEPTH);
      check_now();
      tick();
    end
    check_now();
    chk("reset busy_cnt", 64'(busy_cnt), 64'd0);

    // Writes to register 0 are discarded.
    we = 2'b01; wr_addr = '0; wr_data = 32'hDEADBEEF; set_rd(0, 0, 0);
    check_now();
    tick();
    idle();
    check_now();
    chk("r0 after write", 64'(port_data(0)), 64'd0);
    chk("r0 write busy_cnt", 64'(busy_cnt), 64'd0);
    tick();

    // Link write with forwarding on both destinations.
    we = 2'b11; wr_addr = AW'(5); wr_data = 32'h1234; set_rd(5, 1, 2);
    check_now();
    chk("link fwd r5", 64'(port_data(0)), 64'h1234);
    chk("link fwd r1", 64'(port_data(1)), 64'h1234);
    tick();
    idle();
    check_now();
    chk("link r5 stored", 64'(port_data(0)), 64'h1234);
    chk("link r1 stored", 64'(port_data(1)), 64'h1234);
    tick();

    // Scoreboard set, re-set and clear.
    sb_set = 1'b1; sb_addr = AW'(7); set_rd(7, 9, 0);
    check_now();
    tick();
    sb_addr = AW'(9);
    check_now();
    chk("sb cnt after r7", 64'(busy_cnt), 64'd1);
    tick();
    sb_addr = AW'(7);
    check_now();
    chk("sb cnt after r9", 64'(busy_cnt), 64'd2);
    tick();
    idle();
    check_now();
    chk("sb cnt after r7 again", 64'(busy_cnt), 64'd2);
    chk("rd_busy r7", 64'(rd_busy[0]), 64'd1);
    tick();
    we = 2'b01; wr_addr = AW'(7); wr_data = 32'hA5;
    check_now();
    chk("rd_busy r7 on write", 64'(rd_busy[0]), 64'd0);
    chk("rd_data r7 on write", 64'(port_data(0)), 64'hA5);
    tick();
    idle();
    check_now();
    chk("cnt after r7 write", 64'(busy_cnt), 64'd1);

    // Same-cycle set and write on a pending register keeps it pending.
    sb_set = 1'b1; sb_addr = AW'(3); set_rd(3, 9, 7);
    tick();
    we = 2'b01; wr_addr = AW'(3); wr_data = 32'h33;
    check_now();
    tick();
    idle();
    check_now();
    chk("set+clr cnt", 64'(busy_cnt), 64'd2);
    chk("set+clr rd_busy r3", 64'(rd_busy[0]), 64'd1);
    tick();

    // Reset beats a same-cycle write.
    we = 2'b01; wr_addr = AW'(2); wr_data = 32'h55;
    tick();
    idle(); sb_set = 1'b1; sb_addr = AW'(2);
    tick();
    sb_addr = AW'(4);
    tick();
    idle(); set_rd(2, 4, 3);
    check_now();
    chk("pre-rst r2", 64'(port_data(0)), 64'h55);
    rst_n = 1'b0; we = 2'b01; wr_addr = AW'(2); wr_data = 32'h77;
    tick();
    rst_n = 1'b1; idle();
    check_now();
    chk("post-rst r2", 64'(port_data(0)), 64'd0);
    chk("post-rst cnt", 64'(busy_cnt), 64'd0);
    chk("post-rst rd_busy", 64'(rd_busy), 64'd0);

    // Fill the scoreboard to its maximum.
    for (int a = 1; a < int'(DEPTH); a++) begin
      sb_set = 1'b1; sb_addr = AW'(a);
      tick();
    end
    idle();
    check_now();
    chk("full cnt", 64'(busy_cnt), 64'(DEPTH - 1));
    sb_set = 1'b1; sb_addr = AW'(DEPTH - 1);
    tick();
    idle();
    check_now();
    chk("full cnt re-set", 64'(busy_cnt), 64'(DEPTH - 1));

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int a0;
      rst_n   = ($urandom_range(0, 99) != 0);
      we      = 2'($urandom);
      wr_addr = AW'($urandom);
      wr_data = $urandom;
      sb_set  = ($urandom_range(0, 2) != 0);
      sb_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      a0      = ($urandom_range(0, 2) == 0) ? int'(wr_addr) : int'($urandom_range(0, DEPTH - 1));
      set_rd(a0, ($urandom_range(0, 3) == 0) ? int'(LINK) : int'($urandom_range(0, DEPTH - 1)), a0);
      check_now();
      tick();
    end
    rst_n = 1'b1;
    idle();
    check_now();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
